proj_fm_serializer: RTL
=======================

PROJ_FM_SERIALIZER -- requirements
Module: proj_fm_serializer

Interface
REQ-001 SHALL have parameter BUFFER_COUNT, default 2: number of chunk slots buffered (>=1).
REQ-002 SHALL have parameter RAMS, default 2: RAM banks per feature-map frame.
REQ-003 SHALL have parameter ENTRIES, default 2: entries per bank.
REQ-004 SHALL have parameter OFFSET, default 1: words per entry.
REQ-005 SHALL have parameter CHUNK_SIZE, default 2: words per input chunk; FRAME_WORDS = RAMS*ENTRIES*OFFSET SHALL be a multiple of CHUNK_SIZE.
REQ-006 SHALL have parameter DATA_BITS, default 8: bits per word.
REQ-007 SHALL have port in_clk  input  1  sole clock, rising edge.
REQ-008 SHALL have port in_rst  input  1  reset, synchronous, active-high.
REQ-009 SHALL have port in_valid  input  1  in_rdata holds a valid chunk.
REQ-010 SHALL have port in_ready  output  1  block can accept a chunk this cycle.
REQ-011 SHALL have port in_rdata  input  CHUNK_SIZE*DATA_BITS  chunk; word k = bits [k*DATA_BITS +: DATA_BITS].
REQ-012 SHALL have port out_valid  output  1  out_wdata holds a valid word.
REQ-013 SHALL have port out_ready  input  1  consumer accepts the word this cycle.
REQ-014 SHALL have port out_wdata  output  DATA_BITS  current word.
REQ-015 SHALL have port out_last  output  1  current word is the last word of a frame.
REQ-016 SHALL have port out_level  output  $clog2(BUFFER_COUNT+1)  number of occupied chunk slots.

Function
REQ-017 SHALL store chunks in a BUFFER_COUNT-deep circular buffer with write pointer, read pointer, and occupancy count.
REQ-018 SHALL drive in_ready = (count < BUFFER_COUNT), from registers only; no combinational path from out_ready or in_valid.
REQ-019 SHALL accept a chunk on a rising edge with in_valid && in_ready, writing it to the write-pointer slot and advancing the pointer modulo BUFFER_COUNT.
REQ-020 SHALL drive out_valid = (count != 0); an accepted chunk is first visible on out_wdata the cycle after acceptance (latency 1, no bypass).
REQ-021 SHALL drive out_wdata = word word_idx of the read-pointer slot, words emitted k=0 first up to k=CHUNK_SIZE-1.
REQ-022 SHALL, on out_valid && out_ready, increment word_idx; at word_idx == CHUNK_SIZE-1 wrap word_idx to 0, advance read pointer modulo BUFFER_COUNT, and free the slot.
REQ-023 SHALL hold out_wdata, out_last and word_idx stable while out_valid && !out_ready.
REQ-024 SHALL, on simultaneous chunk accept and final-word pop, keep count unchanged; accept alone increments, final-word pop alone decrements.
REQ-025 SHALL, when count == BUFFER_COUNT, refuse input that cycle even if the final word is popped the same cycle (in_ready rises the next cycle).
REQ-026 SHALL keep a frame word counter 0..FRAME_WORDS-1, incremented on each word handshake, wrapping to 0 after FRAME_WORDS-1.
REQ-027 SHALL drive out_last = out_valid && (frame counter == FRAME_WORDS-1).
REQ-028 SHALL ignore in_rdata when in_valid is low; pointer arithmetic SHALL wrap correctly for non-power-of-two BUFFER_COUNT.

Reset
REQ-029 SHALL, while in_rst is high at a rising edge, clear pointers, count, word_idx and frame counter to 0; outputs then read out_valid=0, out_last=0, out_level=0, in_ready=1.
REQ-030 SHALL discard all buffered chunks and any partially emitted chunk on reset asserted mid-operation; slot contents need not be cleared.
REQ-031 SHALL ignore in_valid and out_ready in any cycle in which in_rst is high.

Verification (defaults: FRAME_WORDS=4)
REQ-032 Reset: hold in_rst 2 cycles -> out_valid=0, out_last=0, out_level=0, in_ready=1.
REQ-033 Single chunk: push in_rdata=16'h0100, out_ready=1 -> next cycle out_wdata=8'h00, following cycle 8'h01, then out_valid=0.
REQ-034 Backpressure/full: out_ready=0, in_valid=1 with chunks 16'h0100, 16'h0302, 16'h0504 -> first two accepted, in_ready=0 and out_level=2 thereafter, third held until a slot frees.
REQ-035 Simultaneous: count=1, pop final word while pushing new chunk same cycle -> out_level stays 1, new chunk's word 0 appears next cycle.
REQ-036 Streaming: 8 frames, word i+4*frame, out_ready=1 -> words 8'h00..8'h1F in order, out_last high exactly on 8'h03, 8'h07, ..., 8'h1F.
REQ-037 Mid-chunk reset: assert in_rst after word 0 of a two-chunk backlog -> out_valid=0, out_level=0 next cycle; next pushed chunk emits its word 0 with frame counter restarted (out_last on 4th word after reset).

Source files
------------

// File: rtl/proj_fm_serializer.sv
// Chunk-to-word serializer: buffers CHUNK_SIZE-word chunks in a circular buffer and
// emits them one word per handshake, flagging the last word of each feature-map frame.
module proj_fm_serializer #(
  parameter int BUFFER_COUNT = 2,
  parameter int RAMS         = 2,
  parameter int ENTRIES      = 2,
  parameter int OFFSET       = 1,
  parameter int CHUNK_SIZE   = 2,
  parameter int DATA_BITS    = 8
) (
  input  logic                                 in_clk,
  input  logic                                 in_rst,
  input  logic                                 in_valid,
  output logic                                 in_ready,
  input  logic [CHUNK_SIZE*DATA_BITS-1:0]      in_rdata,
  output logic                                 out_valid,
  input  logic                                 out_ready,
  output logic [DATA_BITS-1:0]                 out_wdata,
  output logic                                 out_last,
  output logic [$clog2(BUFFER_COUNT+1)-1:0]    out_level
);

  localparam int FRAME_WORDS = RAMS * ENTRIES * OFFSET;
  localparam int PTR_W  = (BUFFER_COUNT > 1) ? $clog2(BUFFER_COUNT) : 1;
  localparam int LVL_W  = $clog2(BUFFER_COUNT + 1);
  localparam int IDX_W  = (CHUNK_SIZE > 1) ? $clog2(CHUNK_SIZE) : 1;
  localparam int FCNT_W = (FRAME_WORDS > 1) ? $clog2(FRAME_WORDS) : 1;

  localparam logic [PTR_W-1:0]  PTR_LAST  = PTR_W'(BUFFER_COUNT - 1);
  localparam logic [LVL_W-1:0]  LVL_FULL  = LVL_W'(BUFFER_COUNT);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(CHUNK_SIZE - 1);
  localparam logic [FCNT_W-1:0] FCNT_LAST = FCNT_W'(FRAME_WORDS - 1);

  logic [CHUNK_SIZE-1:0][DATA_BITS-1:0] slots [BUFFER_COUNT];

  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [LVL_W-1:0]  count;
  logic [IDX_W-1:0]  word_idx;
  logic [FCNT_W-1:0] frame_cnt;

  logic accept;
  logic pop_word;
  logic pop_chunk;

  // Explicit compare-and-wrap so non-power-of-two depths wrap correctly.
  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
  endfunction

  // All handshake qualifiers derive from registered state only.
  assign in_ready  = (count < LVL_FULL);
  assign out_valid = (count != '0);
  assign out_level = count;
  assign out_wdata = slots[rd_ptr][word_idx];
  assign out_last  = out_valid && (frame_cnt == FCNT_LAST);

  assign accept    = in_valid && in_ready && !in_rst;
  assign pop_word  = out_valid && out_ready && !in_rst;
  assign pop_chunk = pop_word && (word_idx == IDX_LAST);

  always_ff @(posedge in_clk) begin
    if (in_rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      word_idx  <= '0;
      frame_cnt <= '0;
    end else begin
      if (accept) begin
        wr_ptr <= ptr_next(wr_ptr);
      end
      if (pop_word) begin
        word_idx  <= (word_idx == IDX_LAST) ? '0 : word_idx + IDX_W'(1);
        frame_cnt <= (frame_cnt == FCNT_LAST) ? '0 : frame_cnt + FCNT_W'(1);
      end
      if (pop_chunk) begin
        rd_ptr <= ptr_next(rd_ptr);
      end
      case ({accept, pop_chunk})
        2'b10:   count <= count + LVL_W'(1);
        2'b01:   count <= count - LVL_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Slot storage carries data only; reset leaves stale contents, which are unreachable.
  always_ff @(posedge in_clk) begin
    if (accept) begin
      slots[wr_ptr] <= in_rdata;
    end
  end

endmodule
